// File: rtl/float_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// float_multiplier_pipe -- LAT-stage FP mantissa/exponent multiply with
// NaN/inf/zero handling and a global-stall valid/ready pipeline.
// Revision: 1.0
// ============================================================================
module float_multiplier_pipe #(
  parameter int EW    = 8,
  parameter int MW    = 23,
  parameter int LAT   = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             valid_out,
  input  logic             ready_in,
  input  logic [4:0]       op,
  input  logic [2:0]       rm,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out,
  input  logic [MW:0]      man_a,
  input  logic [EW+1:0]    exp_a,
  input  logic             sgn_a,
  input  logic             zero_a,
  input  logic             inf_a,
  input  logic             sNaN_a,
  input  logic             qNaN_a,
  input  logic [MW:0]      man_b,
  input  logic [EW+1:0]    exp_b,
  input  logic             sgn_b,
  input  logic             zero_b,
  input  logic             inf_b,
  input  logic             sNaN_b,
  input  logic             qNaN_b,
  output logic [MW:0]      man_y,
  output logic [EW+1:0]    exp_y,
  output logic             sgn_y,
  output logic             round_bit,
  output logic             sticky_bit,
  output logic             skip_round,
  output logic             IV,
  output logic [2:0]       rm_out
);

  localparam logic [4:0]    FPU_OP_MUL  = 5'd2;
  localparam int            PW          = 2 * (MW + 1);
  localparam int            NR          = (LAT > 1) ? LAT - 1 : 1;
  localparam logic [MW:0]   MAN_QNAN    = {2'b11, {(MW - 1){1'b0}}};
  localparam logic [MW:0]   MAN_INF     = {1'b1, {MW{1'b0}}};
  localparam logic [EW+1:0] EXP_SPECIAL = {2'b00, {EW{1'b1}}};
  localparam logic [EW+1:0] EXP_ONE     = {{(EW + 1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [PW-1:0]    p;
    logic [EW+1:0]    exp_sum;
    logic             sgn;
    logic             nan;
    logic             inf;
    logic             zero;
    logic             iv;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } raw_t;

  typedef struct packed {
    logic [MW:0]      man;
    logic [EW+1:0]    exp;
    logic             sgn;
    logic             rnd;
    logic             stk;
    logic             skip;
    logic             iv;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } res_t;

  // Special cases win in priority order NaN > inf > zero; round/sticky stay 0 for all of them.
  function automatic res_t normalize(input raw_t r);
    res_t o;
    o      = '0;
    o.sgn  = r.sgn;
    o.rm   = r.rm;
    o.tag  = r.tag;
    o.skip = r.nan | r.inf | r.zero;
    if (r.nan) begin
      o.man = MAN_QNAN;
      o.exp = EXP_SPECIAL;
      o.sgn = 1'b0;
      o.iv  = r.iv;
    end else if (r.inf) begin
      o.man = MAN_INF;
      o.exp = EXP_SPECIAL;
    end else if (!r.zero) begin
      if (r.p[PW-1]) begin
        o.man = r.p[PW-1:MW+1];
        o.exp = r.exp_sum + EXP_ONE;
        o.rnd = r.p[MW];
        o.stk = |r.p[MW-1:0];
      end else begin
        o.man = r.p[PW-2:MW];
        o.exp = r.exp_sum;
        o.rnd = r.p[MW-1];
        o.stk = |r.p[MW-2:0];
      end
    end
    return o;
  endfunction

  logic stall;
  logic accept;
  raw_t raw_d;
  res_t res_in_d;
  logic res_in_v_d;
  res_t res_q [NR];
  logic [NR-1:0] res_v_q;

  assign stall     = valid_out && !ready_in;
  assign ready_out = !stall;
  assign accept    = valid_in && ready_out && (op == FPU_OP_MUL);

  always_comb begin
    raw_d         = '0;
    raw_d.p       = {{(MW + 1){1'b0}}, man_a} * {{(MW + 1){1'b0}}, man_b};
    raw_d.exp_sum = exp_a + exp_b;
    raw_d.sgn     = sgn_a ^ sgn_b;
    raw_d.nan     = sNaN_a | qNaN_a | sNaN_b | qNaN_b | (zero_a & inf_b) | (inf_a & zero_b);
    raw_d.inf     = inf_a | inf_b;
    raw_d.zero    = zero_a | zero_b;
    raw_d.iv      = ~(qNaN_a | qNaN_b);
    raw_d.rm      = rm;
    raw_d.tag     = tag_in;
  end

  // With LAT >= 2 the raw product is registered first and normalized on the way into the result stages.
  generate
    if (LAT == 1) begin : g_lat1
      assign res_in_d   = normalize(raw_d);
      assign res_in_v_d = accept;
    end else begin : g_latn
      raw_t raw_q;
      logic raw_v_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          raw_q   <= '0;
          raw_v_q <= 1'b0;
        end else if (!stall) begin
          raw_q   <= raw_d;
          raw_v_q <= accept;
        end
      end

      assign res_in_d   = normalize(raw_q);
      assign res_in_v_d = raw_v_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) begin
        res_q[i] <= '0;
      end
      res_v_q <= '0;
    end else if (!stall) begin
      res_q[0]   <= res_in_d;
      res_v_q[0] <= res_in_v_d;
      for (int i = 1; i < NR; i++) begin
        res_q[i]   <= res_q[i-1];
        res_v_q[i] <= res_v_q[i-1];
      end
    end
  end

  assign valid_out  = res_v_q[NR-1];
  assign man_y      = res_q[NR-1].man;
  assign exp_y      = res_q[NR-1].exp;
  assign sgn_y      = res_q[NR-1].sgn;
  assign round_bit  = res_q[NR-1].rnd;
  assign sticky_bit = res_q[NR-1].stk;
  assign skip_round = res_q[NR-1].skip;
  assign IV         = res_q[NR-1].iv;
  assign rm_out     = res_q[NR-1].rm;
  assign tag_out    = res_q[NR-1].tag;

endmodule
`default_nettype wire

// File: tb/tb_float_multiplier_pipe.sv
`default_nettype none
// Bench for float_multiplier_pipe: LAT = 2, 1 and 4 instances share one
// stimulus stream; each instance has its own scoreboard queue.
module tb_float_multiplier_pipe;
  localparam int EW = 8;
  localparam int MW = 23;
  localparam int TAG_W = 4;
  localparam int ND = 3;
  localparam int LATS [ND] = '{2, 1, 4};
  localparam logic [4:0] OP_MUL = 5'd2;

  typedef struct packed {
    logic [MW:0]      man;
    logic [EW+1:0]    exp;
    logic             sgn;
    logic [3:0]       flg;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
    int               cyc;
    int               stl;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic valid_in = 1'b0;
  logic ready_main = 1'b1;
  logic [4:0] op = OP_MUL;
  logic [2:0] rm = 3'd0;
  logic [TAG_W-1:0] tag_in = '0;
  logic [MW:0] man_a = '0, man_b = '0;
  logic [EW+1:0] exp_a = '0, exp_b = '0;
  logic sgn_a = 1'b0, zero_a = 1'b0, inf_a = 1'b0, sNaN_a = 1'b0, qNaN_a = 1'b0;
  logic sgn_b = 1'b0, zero_b = 1'b0, inf_b = 1'b0, sNaN_b = 1'b0, qNaN_b = 1'b0;

  logic rdy_in [ND];
  logic rdy_out [ND];
  logic vout [ND];
  logic [MW:0] y_man [ND];
  logic [EW+1:0] y_exp [ND];
  logic y_sgn [ND], y_rnd [ND], y_stk [ND], y_skip [ND], y_iv [ND];
  logic [2:0] y_rm [ND];
  logic [TAG_W-1:0] y_tag [ND];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  exp_t sbq [ND][$];
  int stalls [ND] = '{0, 0, 0};
  logic prev_stall [ND] = '{1'b0, 1'b0, 1'b0};
  logic [45:0] prev_bus [ND];

  always #5 clk = ~clk;

  assign rdy_in[0] = ready_main;
  assign rdy_in[1] = 1'b1;
  assign rdy_in[2] = 1'b1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    float_multiplier_pipe #(.EW(EW), .MW(MW), .LAT(LATS[g]), .TAG_W(TAG_W)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .valid_in(valid_in), .ready_out(rdy_out[g]),
      .valid_out(vout[g]), .ready_in(rdy_in[g]),
      .op(op), .rm(rm), .tag_in(tag_in), .tag_out(y_tag[g]),
      .man_a(man_a), .exp_a(exp_a), .sgn_a(sgn_a), .zero_a(zero_a), .inf_a(inf_a),
      .sNaN_a(sNaN_a), .qNaN_a(qNaN_a),
      .man_b(man_b), .exp_b(exp_b), .sgn_b(sgn_b), .zero_b(zero_b), .inf_b(inf_b),
      .sNaN_b(sNaN_b), .qNaN_b(qNaN_b),
      .man_y(y_man[g]), .exp_y(y_exp[g]), .sgn_y(y_sgn[g]),
      .round_bit(y_rnd[g]), .sticky_bit(y_stk[g]), .skip_round(y_skip[g]),
      .IV(y_iv[g]), .rm_out(y_rm[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [45:0] obus(input int d);
    return {y_man[d], y_exp[d], y_sgn[d], y_rnd[d], y_stk[d], y_skip[d], y_iv[d], y_rm[d], y_tag[d]};
  endfunction

  // Reference result from the currently driven operands.
  function automatic exp_t model();
    exp_t e;
    logic [63:0] p;
    logic nan;
    int sh;
    e     = '0;
    e.rm  = rm;
    e.tag = tag_in;
    e.sgn = sgn_a ^ sgn_b;
    p     = 64'(man_a) * 64'(man_b);
    nan   = sNaN_a || qNaN_a || sNaN_b || qNaN_b || (zero_a && inf_b) || (inf_a && zero_b);
    if (nan) begin
      e.man = 24'hC00000; e.exp = 10'h0FF; e.sgn = 1'b0;
      e.flg = {2'b00, 1'b1, !(qNaN_a || qNaN_b)};
    end else if (inf_a || inf_b) begin
      e.man = 24'h800000; e.exp = 10'h0FF; e.flg = 4'b0010;
    end else if (zero_a || zero_b) begin
      e.flg = 4'b0010;
    end else begin
      sh    = p[47] ? 24 : 23;
      e.man = 24'(p >> sh);
      e.exp = exp_a + exp_b + {9'd0, p[47]};
      e.flg = {p[sh-1], (p & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0, 2'b00};
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int d = 0; d < ND; d++) begin
      if (!reset_n) begin
        sbq[d].delete();
        prev_stall[d] = 1'b0;
      end else begin
        chk($sformatf("d%0d_ready_out", d), rdy_out[d], !(vout[d] && !rdy_in[d]));
        if (prev_stall[d]) chk($sformatf("d%0d_hold", d), obus(d), prev_bus[d]);
        if (vout[d] && rdy_in[d]) begin
          if (sbq[d].size() == 0) begin
            chk($sformatf("d%0d_spurious_out", d), vout[d], 1'b0);
          end else begin
            e = sbq[d].pop_front();
            chk($sformatf("d%0d_man", d), y_man[d], e.man);
            chk($sformatf("d%0d_exp", d), y_exp[d], e.exp);
            chk($sformatf("d%0d_sgn", d), y_sgn[d], e.sgn);
            chk($sformatf("d%0d_rnd_stk_skip_iv", d), {y_rnd[d], y_stk[d], y_skip[d], y_iv[d]}, e.flg);
            chk($sformatf("d%0d_rm", d), y_rm[d], e.rm);
            chk($sformatf("d%0d_tag", d), y_tag[d], e.tag);
            chk($sformatf("d%0d_latency", d), cyc - e.cyc, LATS[d] + stalls[d] - e.stl);
          end
        end
        prev_stall[d] = vout[d] && !rdy_in[d];
        if (prev_stall[d]) stalls[d]++;
        prev_bus[d] = obus(d);
        if (valid_in && rdy_out[d] && op == OP_MUL) begin
          e     = model();
          e.cyc = cyc;
          e.stl = stalls[d];
          sbq[d].push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [MW:0] ma, input logic [EW+1:0] ea, input logic sa, input logic [3:0] fa,
                      input logic [MW:0] mb, input logic [EW+1:0] eb, input logic sb, input logic [3:0] fb,
                      input logic [TAG_W-1:0] tg, input logic [2:0] r, input logic [4:0] o);
    int k = 0;
    man_a = ma; exp_a = ea; sgn_a = sa; {zero_a, inf_a, sNaN_a, qNaN_a} = fa;
    man_b = mb; exp_b = eb; sgn_b = sb; {zero_b, inf_b, sNaN_b, qNaN_b} = fb;
    tag_in = tg; rm = r; op = o; valid_in = 1'b1;
    @(negedge clk);
    while (!rdy_out[0] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("send_timeout", rdy_out[0], 1'b1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic send_rand(input logic [TAG_W-1:0] tg);
    logic [3:0] fa = 4'b0000;
    logic [3:0] fb = 4'b0000;
    case ($urandom_range(0, 15))
      10: fa = 4'b1000;
      11: fb = 4'b0100;
      12: fa = 4'b0010;
      13: fb = 4'b0001;
      14: begin fa = 4'b0100; fb = 4'b1000; end
      15: fa = 4'b0011;
      default: ;
    endcase
    send({1'b1, 23'($urandom)}, 10'($urandom), 1'($urandom), fa,
         {1'b1, 23'($urandom)}, 10'($urandom), 1'($urandom), fb, tg, 3'($urandom), OP_MUL);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d_rst_vout", d), vout[d], 1'b0);
      chk($sformatf("d%0d_rst_ready", d), rdy_out[d], 1'b1);
      chk($sformatf("d%0d_rst_outputs", d), obus(d), 46'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Normal case: 1.5 * 1.5 with exponents 1 and 2.
    send(24'hC00000, 10'd1, 1'b0, 4'b0000, 24'hC00000, 10'd2, 1'b0, 4'b0000, 4'd1, 3'd0, OP_MUL);
    @(negedge clk);
    chk("lat2_not_early", vout[0], 1'b0);
    chk("lat1_on_time", vout[1], 1'b1);
    @(negedge clk);
    chk("norm_vout", vout[0], 1'b1);
    chk("norm_man", y_man[0], 24'h900000);
    chk("norm_exp", y_exp[0], 10'd4);
    chk("norm_rnd_stk", {y_rnd[0], y_stk[0]}, 2'b00);
    wait_drain();

    // zero * inf -> invalid NaN; sign forced positive.
    send(24'h000000, 10'd0, 1'b1, 4'b1000, 24'h800000, 10'd0, 1'b0, 4'b0100, 4'd2, 3'd3, OP_MUL);
    @(negedge clk);
    @(negedge clk);
    chk("nan_vout", vout[0], 1'b1);
    chk("nan_man", y_man[0], 24'hC00000);
    chk("nan_exp", y_exp[0], 10'h0FF);
    chk("nan_sgn", y_sgn[0], 1'b0);
    chk("nan_iv_skip", {y_iv[0], y_skip[0]}, 2'b11);
    wait_drain();

    // Non-multiply ops must be ignored.
    send(24'hC00000, 10'd1, 1'b0, 4'b0000, 24'hC00000, 10'd1, 1'b0, 4'b0000, 4'd7, 3'd0, 5'd0);
    send(24'hC00000, 10'd1, 1'b0, 4'b0000, 24'hC00000, 10'd1, 1'b0, 4'b0000, 4'd8, 3'd0, 5'd3);
    send(24'hC00000, 10'd1, 1'b0, 4'b0000, 24'hC00000, 10'd1, 1'b0, 4'b0000, 4'd9, 3'd0, 5'd31);
    op = OP_MUL;
    repeat (6) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) chk($sformatf("d%0d_opfilter_vout", d), vout[d], 1'b0);
    end

    // Four back-to-back transactions with downstream held off for three stall cycles.
    @(posedge clk); #1;
    ready_main = 1'b0;
    fork
      begin
        for (int t = 1; t <= 4; t++) send_rand(4'(t));
      end
      begin
        int k = 0;
        while (!vout[0] && k < 20) begin
          @(negedge clk);
          k++;
        end
        repeat (3) @(posedge clk);
        #1;
        ready_main = 1'b1;
      end
    join
    wait_drain();

    // Full-throughput burst.
    for (int t = 0; t < 8; t++) send_rand(4'(t));
    wait_drain();

    // Reset with two transactions in flight.
    send(24'hA00000, 10'd5, 1'b0, 4'b0000, 24'hE00000, 10'd6, 1'b1, 4'b0000, 4'd11, 3'd1, OP_MUL);
    send(24'hB00000, 10'd7, 1'b1, 4'b0000, 24'h900000, 10'd8, 1'b0, 4'b0000, 4'd12, 3'd2, OP_MUL);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d_midrst_vout", d), vout[d], 1'b0);
      chk($sformatf("d%0d_midrst_ready", d), rdy_out[d], 1'b1);
      chk($sformatf("d%0d_midrst_outputs", d), obus(d), 46'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(24'hF00000, 10'd3, 1'b0, 4'b0000, 24'hF00000, 10'd4, 1'b0, 4'b0000, 4'd13, 3'd4, OP_MUL);
    wait_drain();

    // Random traffic with random downstream backpressure.
    begin
      bit done = 1'b0;
      fork
        begin
          for (int t = 0; t < 60; t++) send_rand(4'(t));
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk); #1;
            ready_main = ($urandom_range(0, 3) != 0);
          end
          ready_main = 1'b1;
        end
      join
    end
    wait_drain();

    for (int d = 0; d < ND; d++) chk($sformatf("d%0d_drained", d), sbq[d].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/float_multiplier_pipe.md
FLOAT_MULTIPLIER_PIPE -- requirements
Module: float_multiplier_pipe

Interface
REQ-001 SHALL have parameter EW, default 8: exponent field width; internal exponents are EW+2 bits.
REQ-002 SHALL have parameter MW, default 23: fraction width; mantissas are MW+1 bits with the hidden bit at the MSB.
REQ-003 SHALL have parameter LAT, default 2, range 1..8: cycles from accept to valid_out, absent backpressure.
REQ-004 SHALL have parameter TAG_W, default 4: width of the pass-through tag.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports valid_in input 1 and ready_out output 1: upstream handshake.
REQ-008 SHALL have ports valid_out output 1 and ready_in input 1: downstream handshake.
REQ-009 SHALL have ports op input 5 (FPU operation code) and rm input 3 (rounding mode).
REQ-010 SHALL have ports tag_in input TAG_W and tag_out output TAG_W: opaque transaction tag.
REQ-011 SHALL have operand-A ports: man_a input MW+1, exp_a input EW+2, and sgn_a, zero_a, inf_a, sNaN_a, qNaN_a, each input 1.
REQ-012 SHALL have operand-B ports with the same names, suffix _b, and the same widths.
REQ-013 SHALL have result ports man_y output MW+1, exp_y output EW+2, sgn_y output 1.
REQ-014 SHALL have status ports round_bit, sticky_bit, skip_round, IV (each output 1) and rm_out output 3.

Function
REQ-015 SHALL accept a transaction only when valid_in && ready_out && op == FPU_OP_MUL; any other op is ignored and leaves state unchanged.
REQ-016 SHALL be fully pipelined: LAT stages, each with a valid bit, throughput one accepted transaction per cycle.
REQ-017 SHALL use a global stall: stall = valid_out && !ready_in; ready_out = !stall; while stalled, every stage holds its contents.
REQ-018 SHALL, when stall is low, advance every stage by one per cycle; an empty stage sets its valid bit to 0.
REQ-019 SHALL present an accepted transaction at valid_out exactly LAT cycles after acceptance if no stall occurs; each stall cycle adds one cycle.
REQ-020 SHALL preserve order; tag_out and rm_out SHALL equal the tag_in and rm captured at acceptance.
REQ-021 SHALL form the full 2(MW+1)-bit product P = man_a*man_b; P may be split across stages in any way that meets LAT.
REQ-022 SHALL compute sgn_y = sgn_a ^ sgn_b, and exp_y = exp_a + exp_b (modulo 2^(EW+2)), plus 1 when P MSB = 1.
REQ-023 SHALL, if P MSB = 1, output man_y = P[2MW+1:MW+1], round_bit = P[MW], sticky_bit = OR of P[MW-1:0].
REQ-024 SHALL, if P MSB = 0, output man_y = P[2MW:MW], round_bit = P[MW-1], sticky_bit = OR of P[MW-2:0].
REQ-025 SHALL treat as NaN case: any sNaN or qNaN operand, zero*inf, or inf*zero.
REQ-026 SHALL output for the NaN case: man_y = 2'b11 followed by zeros, exp_y = 2^EW-1, sgn_y = 0, skip_round = 1, IV = !(qNaN_a || qNaN_b).
REQ-027 SHALL output for the inf case (else, inf_a || inf_b): man_y = 1 followed by zeros, exp_y = 2^EW-1, sgn_y = sgn_a^sgn_b, skip_round = 1, IV = 0.
REQ-028 SHALL output for the zero case (else, zero_a || zero_b): man_y = 0, exp_y = 0, sgn_y = sgn_a^sgn_b, skip_round = 1, IV = 0.
REQ-029 SHALL force round_bit = sticky_bit = 0 whenever skip_round = 1.
REQ-030 SHALL pass special cases through the pipeline with the same LAT latency as normal cases; no early exit, order kept.
REQ-031 SHALL, in the same cycle as an output transfer (valid_out && ready_in), accept a new input; with the pipeline full this sustains one transaction per cycle.
REQ-032 SHALL hold all result outputs stable while valid_out && !ready_in.

Reset
REQ-033 SHALL, on reset_n low, immediately clear all stage valid bits; valid_out = 0, ready_out = 1.
REQ-034 SHALL reset to 0 all of: man_y, exp_y, sgn_y, round_bit, sticky_bit, skip_round, IV, rm_out, tag_out.
REQ-035 SHALL discard in-flight transactions on reset mid-operation; the first post-reset output is the first post-reset accept.

Verification
REQ-036 SHALL pass (defaults) normal case: man_a = man_b = 0xC00000, exp_a = 1, exp_b = 2 -> after 2 cycles man_y = 0x900000, exp_y = 4, round = 0, sticky = 0.
REQ-037 SHALL pass NaN case: zero_a = 1, inf_b = 1 -> man_y = 0xC00000, exp_y = 0x0FF, sgn_y = 0, IV = 1, skip_round = 1, latency 2.
REQ-038 SHALL pass backpressure case: 4 back-to-back accepts with tags 1..4 and ready_in low for 3 cycles -> no loss or duplication; tags out 1,2,3,4; ready_out low only while stalled.
REQ-039 SHALL pass op filter: valid_in with op != FPU_OP_MUL -> no valid_out ever, state unchanged.
REQ-040 SHALL pass reset mid-flight: reset_n pulsed low with 2 in flight -> valid_out = 0 at once; neither result ever appears.
REQ-041 SHALL pass LAT = 1 and LAT = 4 regressions: latency equals LAT, full throughput.
